alu_share_arb: RTL and testbench
================================

// Module: alu_share_arb
// PURPOSE
// - Shares one 4-bit ALU (func set: add, sub, not, and, or, xor, slt, eq) among N requesters.
// - Arbitrates requests, drives the ALU operand/func inputs, samples the result after ALU_LAT cycles,
//   and returns it with a requester id over a valid/ready response channel.
// - Sits between requester logic and the existing adder-based ALU; the ALU itself stays unchanged.
// PARAMETERS
// - N        4  number of requesters (2..8)
// - IDW      2  width of rsp_id; must be >= clog2(N)
// - ALU_LAT  1  cycles from stable alu_* outputs to valid alu_result (>=1)
// PORTS
// - clk           in   1     clock, rising edge
// - rst           in   1     synchronous reset, active-high
// - req_valid     in   N     per-requester request valid
// - req_ready     out  N     one-hot grant; transfer when req_valid[i] & req_ready[i]
// - req_func      in   3*N   op code, requester i at [3i+2:3i]
// - req_a         in   4*N   operand a, requester i at [4i+3:4i]
// - req_b         in   4*N   operand b, requester i at [4i+3:4i]
// - alu_func      out  3     to ALU func select
// - alu_a         out  4     to ALU operand a
// - alu_b         out  4     to ALU operand b
// - alu_result    in   4     from ALU result (sum or logic output per func)
// - alu_cout      in   1     from ALU carry out
// - alu_overflow  in   1     from ALU overflow
// - rsp_valid     out  1     response valid
// - rsp_ready     in   1     response accepted
// - rsp_id        out  IDW   index of requester that owns the response
// - rsp_result    out  4     sampled alu_result
// - rsp_flags     out  3     {overflow, cout, zero}; zero = (alu_result == 4'd0)
// - busy          out  1     high in EXEC or RESP
// BEHAVIOUR
// - Reset: state=IDLE; rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, busy=0, req_ready=0,
//   alu_func/alu_a/alu_b=0, RR pointer=0, wait counter=0. req_ready is 0 during any rst cycle.
// - FSM IDLE -> EXEC -> RESP -> IDLE.
// - IDLE: if any req_valid, req_ready[g]=1 (combinational, same cycle) for the granted index g only.
//   On transfer: latch func/a/b into the alu_* registers, latch g into the id register,
//   load counter=ALU_LAT, go to EXEC. If no req_valid, req_ready=0 and state stays IDLE.
// - EXEC: alu_* held stable; counter decrements each cycle; in the cycle the counter is 1, sample
//   alu_result/alu_cout/alu_overflow into the rsp_* registers and go to RESP.
// - RESP: rsp_valid=1; rsp_* held stable until rsp_ready=1, then go to IDLE. No grant is issued while
//   in EXEC or RESP. Never more than one op is in flight.
// - Latency: grant in cycle T -> rsp_valid in cycle T+1+ALU_LAT. Minimum issue interval ALU_LAT+2 cycles.
// - alu_* keep the last op values after RESP; they change only on a new transfer.
// - Flags pass through for every func; logic ops still report the ALU's cout/overflow as presented.
// - A requester may drop req_valid before it is granted; only the current-cycle req_valid is used.
// - Reset mid-operation: in-flight op and pending response are discarded; the next state is IDLE.
// CONFIGURATION
// - ALU_SHARE_ARB_RR_EN defined: round-robin arbitration. Search starts at pointer p and proceeds
//   p, p+1, ..., wrapping N-1 -> 0. On transfer p = g+1 (wraps to 0 after N-1); otherwise unchanged.
// - Not defined: fixed priority; the lowest valid index wins; no pointer state.
// TESTING (model ALU: add/sub via 4-bit adder, ALU_LAT=1)
// - rst=1 for 2 cycles -> rsp_valid=0, req_ready=0, busy=0, alu_a=alu_b=alu_func=0.
// - req_valid[0], func=000, a=3, b=5 -> req_ready=0001 same cycle; rsp_valid 2 cycles later,
//   rsp_result=8, rsp_id=0, rsp_flags={1,0,0} (3+5 overflows 4-bit signed).
// - req2 func=001, a=4, b=4 -> rsp_result=0, zero flag=1, rsp_id=2.
// - req_valid=1111 held, rsp_ready=1: RR_EN grants 0,1,2,3,0; without RR_EN grants 0,0,0,0.
// - rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0, busy=1; rsp_ready=1 -> IDLE next cycle.
// - rst=1 during EXEC -> next cycle IDLE, rsp_valid never rises; then req1 add 1+1 -> rsp_result=2, rsp_id=1.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one external 4-bit ALU among N requesters over a valid/ready response channel
// Ports: clk, rst (sync, active-high); req_valid/req_ready (one-hot grant), req_func/req_a/req_b (packed per requester);
//        alu_func/alu_a/alu_b to the ALU, alu_result/alu_cout/alu_overflow from it;
//        rsp_valid/rsp_ready, rsp_id, rsp_result, rsp_flags {overflow, cout, zero}; busy in EXEC or RESP.
// Build option: define ALU_SHARE_ARB_RR_EN for round-robin arbitration, otherwise fixed priority (lowest index wins).
module alu_share_arb #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [3*N-1:0]   req_func,
  input  logic [4*N-1:0]   req_a,
  input  logic [4*N-1:0]   req_b,
  output logic [2:0]       alu_func,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [3:0]       alu_result,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [3:0]       rsp_result,
  output logic [2:0]       rsp_flags,
  output logic             busy
);
  localparam int CW = $clog2(ALU_LAT + 1);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [IDW-1:0] r_id;
  logic [2:0]     r_func;
  logic [3:0]     r_a;
  logic [3:0]     r_b;
  logic [3:0]     r_res;
  logic [2:0]     r_flags;
  logic [IDW-1:0] w_gnt;
  logic           w_xfer;
`ifdef ALU_SHARE_ARB_RR_EN
  logic [IDW-1:0] r_ptr;
`endif
  // Descending scan so the first valid index in search order is the one left standing.
  always_comb begin
    w_gnt = '0;
    for (int k = N - 1; k >= 0; k--)
`ifdef ALU_SHARE_ARB_RR_EN
      if (req_valid[(int'(r_ptr) + k) % N]) w_gnt = IDW'((int'(r_ptr) + k) % N);
`else
      if (req_valid[k]) w_gnt = IDW'(k);
`endif
  end
  assign req_ready  = (r_state == IDLE && !rst && |req_valid) ? N'(1) << w_gnt : '0;
  assign w_xfer     = |(req_valid & req_ready);
  assign alu_func   = r_func;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign rsp_valid  = r_state == RESP;
  assign rsp_id     = r_id;
  assign rsp_result = r_res;
  assign rsp_flags  = r_flags;
  assign busy       = r_state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_id    <= '0;
      r_func  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_flags <= '0;
`ifdef ALU_SHARE_ARB_RR_EN
      r_ptr   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_xfer) begin
          r_func  <= req_func[3*int'(w_gnt) +: 3];
          r_a     <= req_a[4*int'(w_gnt) +: 4];
          r_b     <= req_b[4*int'(w_gnt) +: 4];
          r_id    <= w_gnt;
          r_cnt   <= CW'(ALU_LAT);
          r_state <= EXEC;
`ifdef ALU_SHARE_ARB_RR_EN
          r_ptr   <= (w_gnt == IDW'(N - 1)) ? '0 : w_gnt + 1'b1;
`endif
        end
        EXEC: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_res   <= alu_result;
            r_flags <= {alu_overflow, alu_cout, alu_result == 4'd0};
            r_state <= RESP;
          end
        end
        RESP: if (rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: scoreboard bench for alu_share_arb with a behavioural ALU and arbitration model
module tb_alu_share_arb;
  localparam int N = 4, IDW = 2, LAT = 1;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [3*N-1:0] req_func;
  logic [4*N-1:0] req_a;
  logic [4*N-1:0] req_b;
  logic [2:0]     alu_func;
  logic [3:0]     alu_a;
  logic [3:0]     alu_b;
  logic [3:0]     alu_result;
  logic           alu_cout;
  logic           alu_overflow;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [IDW-1:0] rsp_id;
  logic [3:0]     rsp_result;
  logic [2:0]     rsp_flags;
  logic           busy;
  logic [2:0] op_f[N];
  logic [3:0] op_a[N];
  logic [3:0] op_b[N];
  logic [2:0] n_f[N];
  logic [3:0] n_a[N];
  logic [3:0] n_b[N];
  int checks = 0, errors = 0, cyc = 0, ptr = 0, grant_cyc = 0;
  bit outstanding = 0;
  logic [2:0] m_f = '0;
  logic [3:0] m_a = '0, m_b = '0;
  logic [IDW+6:0] q[$];
  logic [5:0] w_alu;

  always #5 clk = ~clk;

  alu_share_arb #(.N(N), .IDW(IDW), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_a(req_a), .req_b(req_b),
    .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy));

  // Reference ALU: returns {overflow, cout, result}; logic ops report the a+b adder flags.
  function automatic logic [5:0] alu_fn(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] bb, r;
    logic [4:0] s;
    bb = (f == 3'd1) ? ~b : b;
    s = {1'b0, a} + {1'b0, bb} + {4'd0, f == 3'd1};
    case (f)
      3'd0, 3'd1: r = s[3:0];
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = {3'd0, $signed(a) < $signed(b)};
      default: r = {3'd0, a == b};
    endcase
    return {(a[3] == bb[3]) && (s[3] != a[3]), s[4], r};
  endfunction

  assign w_alu = alu_fn(alu_func, alu_a, alu_b);
  assign {alu_overflow, alu_cout, alu_result} = w_alu;

  always_comb begin
    req_func = '0;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_func[3*i +: 3] = op_f[i];
      req_a[4*i +: 4] = op_a[i];
      req_b[4*i +: 4] = op_b[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic step(input logic [N-1:0] v, input logic rr, input logic r);
    int g;
    logic [5:0] e;
    logic [N-1:0] er;
    logic ev;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      op_f[i] = n_f[i];
      op_a[i] = n_a[i];
      op_b[i] = n_b[i];
    end
    req_valid = v;
    rsp_ready = rr;
    rst = r;
    #1;
    if (r) begin
      chk("ready_in_rst", 32'(req_ready), 32'(0));
      outstanding = 0;
      q.delete();
      ptr = 0;
      m_f = '0;
      m_a = '0;
      m_b = '0;
    end else begin
      ev = outstanding && cyc >= grant_cyc + 1 + LAT;
      g = outstanding ? -1 : pick(v, ptr);
      er = (g < 0) ? '0 : N'(1) << g;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(outstanding));
      chk("alu_ops", {21'd0, alu_func, alu_a, alu_b}, {21'd0, m_f, m_a, m_b});
      if (ev && rr) outstanding = 0;
      if (g >= 0) begin
        m_f = op_f[g];
        m_a = op_a[g];
        m_b = op_b[g];
        e = alu_fn(m_f, m_a, m_b);
        q.push_back({IDW'(g), e[3:0], e[5], e[4], e[3:0] == 4'd0});
        outstanding = 1;
        grant_cyc = cyc;
`ifdef ALU_SHARE_ARB_RR_EN
        ptr = (g + 1) % N;
`endif
      end
    end
    cyc++;
  endtask

  task automatic expect_rsp(input string nm, input logic [IDW-1:0] id, input logic [3:0] res, input logic [2:0] fl);
    repeat (LAT + 1) step('0, 1'b0, 1'b0);
    chk({nm, "_valid"}, 32'(rsp_valid), 32'(1));
    chk({nm, "_id"}, 32'(rsp_id), 32'(id));
    chk({nm, "_result"}, 32'(rsp_result), 32'(res));
    chk({nm, "_flags"}, 32'(rsp_flags), 32'(fl));
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < N; i++) begin
      n_f[i] = 3'($urandom);
      n_a[i] = 4'($urandom);
      n_b[i] = 4'($urandom);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'(0));
      else begin
        chk("rsp_data", 32'({rsp_id, rsp_result, rsp_flags}), 32'(q[0]));
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      n_f[i] = '0; n_a[i] = '0; n_b[i] = '0;
      op_f[i] = '0; op_a[i] = '0; op_b[i] = '0;
    end
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    repeat (2) step('0, 1'b0, 1'b0);
    n_f[0] = 3'd0; n_a[0] = 4'd3; n_b[0] = 4'd5;
    step(4'b0001, 1'b0, 1'b0);
    expect_rsp("add_3_5", 2'd0, 4'd8, 3'b100);
    step('0, 1'b1, 1'b0);
    n_f[2] = 3'd1; n_a[2] = 4'd4; n_b[2] = 4'd4;
    step(4'b0100, 1'b0, 1'b0);
    expect_rsp("sub_4_4", 2'd2, 4'd0, 3'b011);
    step('0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      randomize_ops();
      step(4'hF, 1'b1, 1'b0);
    end
    repeat (4) step('0, 1'b1, 1'b0);
    randomize_ops();
    step(4'hF, 1'b0, 1'b0);
    repeat (8) step(4'hF, 1'b0, 1'b0);
    repeat (3) step(4'hF, 1'b1, 1'b0);
    repeat (4) step('0, 1'b1, 1'b0);
    n_f[0] = 3'd0; n_a[0] = 4'd7; n_b[0] = 4'd7;
    step(4'b0001, 1'b0, 1'b0);
    step('0, 1'b1, 1'b1);
    repeat (4) step('0, 1'b1, 1'b0);
    n_f[1] = 3'd0; n_a[1] = 4'd1; n_b[1] = 4'd1;
    step(4'b0010, 1'b0, 1'b0);
    expect_rsp("add_1_1", 2'd1, 4'd2, 3'b000);
    step('0, 1'b1, 1'b0);
    for (int i = 0; i < 600; i++) begin
      randomize_ops();
      step(N'($urandom), ($urandom % 4) != 0, ($urandom % 100) == 0);
    end
    repeat (10) step('0, 1'b1, 1'b0);
    chk("queue_empty", 32'(q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
